// File: rtl/rvfpm_result_buffer.sv
// rvfpm_result_buffer: in-order holding buffer between the FPU execute stage
// and the XIF result channel. Completed results wait here until the core
// commits or kills their instruction ID; committed heads are returned with a
// valid/ready handshake, killed heads are silently dropped.
module rvfpm_result_buffer #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [X_ID_WIDTH-1:0]    in_id,
  input  logic [XLEN-1:0]          in_data,
  input  logic [4:0]               in_rd,
  input  logic                     in_we,
  input  logic [4:0]               in_fflags,
  input  logic                     commit_valid,
  input  logic [X_ID_WIDTH-1:0]    commit_id,
  input  logic                     commit_kill,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [X_ID_WIDTH-1:0]    result_id,
  output logic [XLEN-1:0]          result_data,
  output logic [4:0]               result_rd,
  output logic                     result_we,
  output logic [4:0]               result_fflags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CW      = PTR_W + 1;
  localparam int NUM_IDS = 1 << X_ID_WIDTH;

  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Entry storage, one slot per buffer position.
  logic [X_ID_WIDTH-1:0] id_mem_r     [DEPTH];
  logic [XLEN-1:0]       data_mem_r   [DEPTH];
  logic [4:0]            rd_mem_r     [DEPTH];
  logic                  we_mem_r     [DEPTH];
  logic [4:0]            fflags_mem_r [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CW-1:0]         count_r;

  // Per-ID scoreboard: commit seen, and whether that commit was a kill.
  logic [NUM_IDS-1:0]    committed_r;
  logic [NUM_IDS-1:0]    killed_r;

  logic                  non_empty_s;
  logic [X_ID_WIDTH-1:0] head_id_s;
  logic                  head_killed_s;
  logic                  head_committed_s;
  logic                  present_s;
  logic                  drop_s;
  logic                  pop_s;
  logic                  push_s;

  // Head decode from registered state only; no commit-to-result bypass.
  always_comb begin
    non_empty_s      = (count_r != CNT_ZERO);
    head_id_s        = id_mem_r[rd_ptr_r];
    head_killed_s    = killed_r[head_id_s];
    head_committed_s = committed_r[head_id_s];
    if (!rst && non_empty_s) begin
      drop_s    = head_killed_s;
      present_s = head_committed_s && !head_killed_s;
    end else begin
      drop_s    = 1'b0;
      present_s = 1'b0;
    end
    // in_ready looks at the registered count only, so a same-cycle pop
    // never frees a slot for a push on a full buffer.
    in_ready = !rst && (count_r < DEPTH_C);
    push_s   = in_valid && in_ready;
    pop_s    = drop_s || (present_s && result_ready);
  end

  // Result channel: head fields while presented, zeros otherwise.
  always_comb begin
    result_valid = present_s;
    if (present_s) begin
      result_id     = head_id_s;
      result_data   = data_mem_r[rd_ptr_r];
      result_rd     = rd_mem_r[rd_ptr_r];
      result_we     = we_mem_r[rd_ptr_r];
      result_fflags = fflags_mem_r[rd_ptr_r];
    end else begin
      result_id     = '0;
      result_data   = '0;
      result_rd     = 5'd0;
      result_we     = 1'b0;
      result_fflags = 5'd0;
    end
  end

  assign count = count_r;

  // Entry storage write on an accepted push.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_mem_r[i]     <= '0;
        data_mem_r[i]   <= '0;
        rd_mem_r[i]     <= 5'd0;
        we_mem_r[i]     <= 1'b0;
        fflags_mem_r[i] <= 5'd0;
      end
    end else if (push_s) begin
      id_mem_r[wr_ptr_r]     <= in_id;
      data_mem_r[wr_ptr_r]   <= in_data;
      rd_mem_r[wr_ptr_r]     <= in_rd;
      we_mem_r[wr_ptr_r]     <= in_we;
      fflags_mem_r[wr_ptr_r] <= in_fflags;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Scoreboard: a commit for an ID takes precedence over the clear caused
  // by popping or dropping that same ID in the same cycle.
  always_ff @(posedge ck) begin
    if (rst) begin
      committed_r <= '0;
      killed_r    <= '0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if (commit_valid && (commit_id == X_ID_WIDTH'(i))) begin
          committed_r[i] <= 1'b1;
          killed_r[i]    <= commit_kill;
        end else if (pop_s && (head_id_s == X_ID_WIDTH'(i))) begin
          committed_r[i] <= 1'b0;
          killed_r[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvfpm_result_buffer.sv
// Self-checking bench for rvfpm_result_buffer: a queue/array model predicts
// every output each cycle, and directed literal checks pin key scenarios.
module tb_rvfpm_result_buffer;

  logic        ck = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_id;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_we;
  logic [4:0]  in_fflags;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic [4:0]  result_fflags;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  rvfpm_result_buffer #(.X_ID_WIDTH(4), .XLEN(32), .DEPTH(4)) dut (
    .ck(ck), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
    .in_rd(in_rd), .in_we(in_we), .in_fflags(in_fflags),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
    .result_fflags(result_fflags), .count(count)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  ff;
  } ent_t;

  ent_t mq[$];
  bit   m_comm[16];
  bit   m_kill[16];
  bit   model_on = 1'b0;
  bit   m_pop, m_push;
  logic [3:0] m_h;

  // Advance the model on each rising edge using the inputs in force.
  always @(posedge ck) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 16; i++) begin
        m_comm[i] = 1'b0;
        m_kill[i] = 1'b0;
      end
    end else begin
      m_pop  = 1'b0;
      m_h    = 4'd0;
      m_push = in_valid && (mq.size() < 4);
      if (mq.size() > 0) begin
        m_h = mq[0].id;
        if (m_kill[m_h]) m_pop = 1'b1;
        else if (m_comm[m_h] && result_ready) m_pop = 1'b1;
      end
      if (m_pop) begin
        m_comm[m_h] = 1'b0;
        m_kill[m_h] = 1'b0;
        void'(mq.pop_front());
      end
      if (commit_valid) begin
        m_comm[commit_id] = 1'b1;
        m_kill[commit_id] = commit_kill;
      end
      if (m_push) mq.push_back('{in_id, in_data, in_rd, in_we, in_fflags});
    end
    model_on = 1'b1;
  end

  // Compare every output against the model mid-cycle.
  always @(negedge ck) begin
    if (model_on) begin
      logic        ev;
      logic [3:0]  eid;
      logic [31:0] edata;
      logic [4:0]  erd, eff;
      logic        ewe;
      ev = 1'b0; eid = 4'd0; edata = 32'd0; erd = 5'd0; ewe = 1'b0; eff = 5'd0;
      if (!rst && mq.size() > 0 && m_comm[mq[0].id] && !m_kill[mq[0].id]) begin
        ev = 1'b1; eid = mq[0].id; edata = mq[0].data;
        erd = mq[0].rd; ewe = mq[0].we; eff = mq[0].ff;
      end
      chk("model_count", 32'(count), 32'(mq.size()));
      chk("model_in_ready", 32'(in_ready), 32'(!rst && mq.size() < 4));
      chk("model_valid", 32'(result_valid), 32'(ev));
      chk("model_id", 32'(result_id), 32'(eid));
      chk("model_data", result_data, edata);
      chk("model_rd", 32'(result_rd), 32'(erd));
      chk("model_we", 32'(result_we), 32'(ewe));
      chk("model_fflags", 32'(result_fflags), 32'(eff));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_id = 4'd0; in_data = 32'd0; in_rd = 5'd0;
    in_we = 1'b0; in_fflags = 5'd0;
    commit_valid = 1'b0; commit_id = 4'd0; commit_kill = 1'b0;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd);
    in_valid = 1'b1; in_id = id; in_data = d; in_rd = rd;
    in_we = 1'b1; in_fflags = 5'(id);
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
  endtask

  initial begin
    rst = 1'b1; result_ready = 1'b0; idle();
    tick(); tick();
    @(negedge ck);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_data", result_data, 32'd0);

    // Single op: push id 3, commit two cycles later.
    rst = 1'b0;
    push(4'd3, 32'h3F80_0000, 5'd5);
    tick(); idle();
    @(negedge ck);
    chk("t1_wait_valid", 32'(result_valid), 32'd0);
    tick();
    commit(4'd3, 1'b0);
    tick(); idle();
    @(negedge ck);
    chk("t1_valid", 32'(result_valid), 32'd1);
    chk("t1_id", 32'(result_id), 32'd3);
    chk("t1_data", result_data, 32'h3F80_0000);
    chk("t1_rd", 32'(result_rd), 32'd5);
    result_ready = 1'b1;
    tick(); result_ready = 1'b0;
    @(negedge ck);
    chk("t1_count_after", 32'(count), 32'd0);

    // Commit before push.
    commit(4'd1, 1'b0);
    tick(); idle();
    tick(); tick();
    push(4'd1, 32'h4000_0001, 5'd7);
    tick(); idle();
    @(negedge ck);
    chk("t2_valid", 32'(result_valid), 32'd1);
    chk("t2_id", 32'(result_id), 32'd1);
    result_ready = 1'b1;
    tick(); result_ready = 1'b0;

    // Kill: id 2 dropped, id 4 presented one cycle after the drop.
    push(4'd2, 32'h0000_0222, 5'd2);
    tick();
    push(4'd4, 32'h0000_0444, 5'd4);
    tick(); idle();
    commit(4'd2, 1'b1);
    tick(); idle();
    commit(4'd4, 1'b0);
    @(negedge ck);
    chk("t3_killed_valid", 32'(result_valid), 32'd0);
    chk("t3_count2", 32'(count), 32'd2);
    tick(); idle();
    @(negedge ck);
    chk("t3_count1", 32'(count), 32'd1);
    chk("t3_valid", 32'(result_valid), 32'd1);
    chk("t3_id", 32'(result_id), 32'd4);
    result_ready = 1'b1;
    tick(); result_ready = 1'b0;
    @(negedge ck);
    chk("t3_empty", 32'(count), 32'd0);

    // Full with backpressure, commits on the same edge as the pushes.
    for (int k = 0; k < 4; k++) begin
      push(4'(8 + k), 32'hA000_0000 + 32'(k), 5'(8 + k));
      commit(4'(8 + k), 1'b0);
      tick();
    end
    idle();
    push(4'd12, 32'hDEAD_BEEF, 5'd12);
    @(negedge ck);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_id", 32'(result_id), 32'd8);
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge ck);
      chk("t4_hold_id", 32'(result_id), 32'd8);
      chk("t4_hold_data", result_data, 32'hA000_0000);
    end
    idle();
    result_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_order", 32'(result_id), 32'(8 + k));
      tick();
      @(negedge ck);
    end
    chk("t4_in_ready_back", 32'(in_ready), 32'd1);
    chk("t4_drained", 32'(count), 32'd0);

    // Back-to-back throughput: push and pop every cycle.
    for (int k = 0; k < 6; k++) begin
      push(4'(k), 32'h5000_0000 + 32'(k), 5'(k));
      commit(4'(k), 1'b0);
      tick();
    end
    idle();
    tick();
    result_ready = 1'b0;
    @(negedge ck);
    chk("tp_count", 32'(count), 32'd0);

    // Ordering: 7 committed first, must wait behind 6.
    push(4'd6, 32'h0000_0666, 5'd6);
    tick();
    push(4'd7, 32'h0000_0777, 5'd7);
    commit(4'd7, 1'b0);
    tick(); idle();
    @(negedge ck);
    chk("t5_wait0", 32'(result_valid), 32'd0);
    chk("t5_count", 32'(count), 32'd2);
    tick(); tick();
    @(negedge ck);
    chk("t5_wait1", 32'(result_valid), 32'd0);
    commit(4'd6, 1'b0);
    tick(); idle();
    @(negedge ck);
    chk("t5_first", 32'(result_id), 32'd6);
    result_ready = 1'b1;
    tick();
    @(negedge ck);
    chk("t5_second_v", 32'(result_valid), 32'd1);
    chk("t5_second", 32'(result_id), 32'd7);
    tick(); result_ready = 1'b0;
    @(negedge ck);
    chk("t5_empty", 32'(count), 32'd0);

    // Reset mid-operation.
    for (int k = 0; k < 3; k++) begin
      push(4'(12 + k), 32'hC000_0000 + 32'(k), 5'(k));
      commit(4'(12 + k), 1'b0);
      tick();
    end
    idle();
    @(negedge ck);
    chk("t6_pending", 32'(count), 32'd3);
    chk("t6_id", 32'(result_id), 32'd12);
    rst = 1'b1;
    @(negedge ck);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_valid", 32'(result_valid), 32'd0);
    tick(); rst = 1'b0;
    @(negedge ck);
    chk("t6_count0", 32'(count), 32'd0);
    chk("t6_valid0", 32'(result_valid), 32'd0);
    push(4'd6, 32'h0000_0606, 5'd6);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge ck);
      chk("t6_unpresented", 32'(result_valid), 32'd0);
      chk("t6_count1", 32'(count), 32'd1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfpm_result_buffer.md
# rvfpm_result_buffer

Downstream stage of the rvfpm coprocessor: buffers completed FPU operations, holds each one until the CORE-V-XIF commit for its instruction ID arrives, then returns it in order on the XIF result channel with a valid/ready handshake. Killed instructions are discarded without producing a result. The block sits between the execute stage of the FPU pipeline and the `xif_result_if` port of the top level.

## Interface
- `X_ID_WIDTH`, 4: instruction ID width; the scoreboard has 2^X_ID_WIDTH entries.
- `XLEN`, 32: result data width.
- `DEPTH`, 4: buffer entries (power of two, 2..16).
- `ck` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: execute stage offers a completed result.
- `in_ready` output 1: buffer accepts; equals `!rst && count < DEPTH`.
- `in_id` input X_ID_WIDTH: ID of the completed instruction.
- `in_data` input XLEN: result value.
- `in_rd` input 5: destination register index.
- `in_we` input 1: result writes an X register.
- `in_fflags` input 5: accrued exception flags NV,DZ,OF,UF,NX.
- `commit_valid` input 1: XIF commit strobe.
- `commit_id` input X_ID_WIDTH: ID being committed.
- `commit_kill` input 1: 1 = kill, 0 = commit.
- `result_valid` output 1: head result offered to the core.
- `result_ready` input 1: core accepts the result.
- `result_id`, `result_data`, `result_rd`, `result_we`, `result_fflags` outputs: head entry fields (X_ID_WIDTH / XLEN / 5 / 1 / 5).
- `count` output $clog2(DEPTH)+1: number of occupied entries.

## Operation
- Circular FIFO with write pointer, read pointer and count. A push happens on `in_valid && in_ready` and stores {id,data,rd,we,fflags}.
- Scoreboard: per-ID bits `committed[id]` and `killed[id]`. `commit_valid` sets `committed[commit_id]` and sets `killed[commit_id]` from `commit_kill`, whether or not the entry is in the buffer yet. Commit may arrive before or after the result.
- Head evaluation uses registered state only, for a non-empty buffer with head ID h:
  - `killed[h]`: the head is dropped at the next edge. `result_valid`=0. The read pointer advances, count decrements, and both bits of h clear.
  - `committed[h] && !killed[h]`: `result_valid`=1. On `result_valid && result_ready` the head pops and both bits of h clear.
  - Otherwise the head waits with `result_valid`=0.
- Strict in-order retirement. An entry behind a waiting head is never returned early.
- Result fields read 0 when `result_valid`=0.
- Once asserted, `result_valid` and all result fields stay stable until the handshake completes.

## Timing
- Reset: count=0, pointers=0, all scoreboard bits 0. `result_valid`=0, result fields 0, count=0, `in_ready`=0 while `rst` is high. Reset mid-operation discards all entries and scoreboard state at that edge.
- Latency: when a result is pushed at edge N into an empty buffer and its commit was registered earlier, `result_valid`=1 in the cycle following edge N.
- A commit in the same cycle as the push of that ID is registered at the same edge, giving the same latency as above.
- A commit arriving while the matching entry is already at the head raises `result_valid` in the cycle after the commit edge. There is no combinational path from commit to result.
- Scoreboard priority: a set from `commit_valid` wins over a clear caused by the pop or drop of the same ID in the same cycle.
- Full buffer: `in_ready`=0. A pop in the same cycle does not raise `in_ready`, so there is no bypass and `in_ready` depends on registered count only.
- Simultaneous push and pop keep count unchanged. Pointers wrap modulo DEPTH.
- Throughput: one push and one pop per cycle. A killed head costs one cycle.

## Test plan
- Reset then single op: push id=3 data=0x3F800000 rd=5 we=1, commit id=3 two cycles later -> `result_valid` rises one cycle after the commit edge with id=3 and data=0x3F800000. With `result_ready`=1, count returns to 0.
- Commit first: commit id=1 at cycle 2, push id=1 at cycle 5 -> `result_valid`=1 in cycle 6.
- Kill: push ids 2,4, kill id=2, commit id=4 -> no result for id 2; id=4 is presented 1 cycle after the drop.
- Backpressure and full: push 4 entries with `result_ready`=0, all committed -> `in_ready`=0 and count=4. Result id and data stay stable over 10 cycles. Then `result_ready`=1 for 4 cycles -> results come out in push order and `in_ready` returns to 1.
- Ordering: push ids 6,7, commit 7 before 6 -> nothing is presented until 6 is committed, then 6 followed by 7.
- Reset mid-operation: 3 committed entries pending, assert `rst` one cycle -> count=0 and `result_valid`=0. A pushed id=6 without a new commit stays unpresented.
